// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC and selects the next address from PC+4 or a
// resolved branch/JAL/JALR target. Supports stall; optional misaligned-target trap with
// acknowledge handshake, enabled by defining PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       IMM_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('h40)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [2:0]        br_type,
  input  logic              zero_flag,
  input  logic              lt_flag,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] rs1,
  input  logic              trap_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              taken,
  output logic              trap,
  output logic [ADDR_W-1:0] trap_addr
);

  // Wide enough to sign-extend imm when it is narrower than the address.
  localparam int unsigned ExtW = (ADDR_W > IMM_W) ? ADDR_W : IMM_W;

  localparam logic [2:0] BrBeq  = 3'b001;
  localparam logic [2:0] BrBne  = 3'b010;
  localparam logic [2:0] BrBlt  = 3'b011;
  localparam logic [2:0] BrBge  = 3'b100;
  localparam logic [2:0] BrJal  = 3'b101;
  localparam logic [2:0] BrJalr = 3'b110;

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] trap_addr_q;
  logic              taken_q;
  logic              trap_q;

  logic [ExtW-1:0]   imm_ext;
  logic [ADDR_W-1:0] imm_a;
  logic [ADDR_W-1:0] imm_sh;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] jalr_tgt;
  logic [ADDR_W-1:0] tgt_raw;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              taken_now;
  logic              misalign;
  logic              unused_bits;

  assign imm_ext  = ExtW'($signed(imm));
  assign imm_a    = imm_ext[ADDR_W-1:0];
  assign imm_sh   = {imm_a[ADDR_W-2:0], 1'b0};
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign jump_tgt = pc_q + imm_sh;
  assign jalr_tgt = (rs1 + imm_a) & ~ADDR_W'(1);
  assign tgt_raw  = (br_type == BrJalr) ? jalr_tgt : jump_tgt;

  // Take decision from the resolved control-flow type and ALU flags.
  always_comb begin
    taken_now = 1'b0;
    if (br_valid) begin
      case (br_type)
        BrBeq:         taken_now = zero_flag;
        BrBne:         taken_now = ~zero_flag;
        BrBlt:         taken_now = lt_flag;
        BrBge:         taken_now = ~lt_flag;
        BrJal, BrJalr: taken_now = 1'b1;
        default:       taken_now = 1'b0;
      endcase
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign    = taken_now & (|tgt_raw[1:0]);
  assign tgt         = tgt_raw;
  assign trap        = trap_q;
  assign trap_addr   = trap_addr_q;
  assign unused_bits = ^imm_ext;
`else
  // Without the trap, misaligned targets are silently word-aligned.
  assign misalign    = 1'b0;
  assign tgt         = {tgt_raw[ADDR_W-1:2], 2'b00};
  assign trap        = 1'b0;
  assign trap_addr   = '0;
  assign unused_bits = ^{imm_ext, trap_q, trap_addr_q};
`endif

  assign next_pc = taken_now ? tgt : pc_plus4;

  // RUN/TRAP state machine owning pc, taken and trap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      taken_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      case (state_q)
        StRun: begin
          if (stall) begin
            taken_q <= 1'b0;
          end else if (misalign) begin
            // pc keeps the address of the faulting control-flow instruction.
            state_q     <= StTrap;
            trap_q      <= 1'b1;
            trap_addr_q <= tgt_raw;
            taken_q     <= 1'b0;
          end else begin
            pc_q    <= next_pc;
            taken_q <= taken_now;
          end
        end
        StTrap: begin
          taken_q <= 1'b0;
          if (trap_ack) begin
            state_q <= StRun;
            pc_q    <= TRAP_VEC;
            trap_q  <= 1'b0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign pc    = pc_q;
  assign taken = taken_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC-V core. It holds the fetch PC register and computes the next address each cycle: PC+4, a conditional branch target (BEQ/BNE/BLT/BGE), JAL or JALR. It supports pipeline stall and an optional misaligned-target trap with acknowledge handshake. It sits between the ALU flag outputs and the instruction-memory address port, replacing the fixed 8-bit, BEQ-only next-address adder.

## Interface
Parameters:
- ADDR_W, 32, PC/address width in bits (min 8)
- IMM_W, 64, immediate width from immgen
- RESET_PC, 0, PC value loaded on reset
- TRAP_VEC, 'h40, PC loaded when a trap is acknowledged

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC this cycle
- br_valid  in  1  a control-flow instruction is resolved this cycle
- br_type  in  3  000 SEQ, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, 110 JALR, 111 reserved (treated as SEQ)
- zero_flag  in  1  ALU result == 0
- lt_flag  in  1  ALU signed rs1 < rs2
- imm  in  IMM_W  sign-extended immediate (halfword units for branch/JAL, bytes for JALR)
- rs1  in  ADDR_W  JALR base register value
- trap_ack  in  1  trap handler accepted; redirect to TRAP_VEC
- pc  out  ADDR_W  current fetch address (registered)
- pc_plus4  out  ADDR_W  pc+4, combinational, used as link value
- taken  out  1  registered, 1 for one cycle after a taken redirect
- trap  out  1  registered, misaligned-target trap pending
- trap_addr  out  ADDR_W  registered, offending target address

## Operation
- States: RUN, TRAP. Reset → RUN.
- Reset values: pc=RESET_PC, taken=0, trap=0, trap_addr=0; pc_plus4=RESET_PC+4.
- Take decision (only when br_valid=1): BEQ zero_flag; BNE !zero_flag; BLT lt_flag; BGE !lt_flag; JAL, JALR always; SEQ/reserved never.
- Targets: branch/JAL = pc + (imm<<1); JALR = (rs1 + imm) with bit0 cleared. All sums are modulo 2^ADDR_W; imm is truncated to ADDR_W after shifting.
- next = taken_now ? target : pc+4. Wrap-around: with ADDR_W=8, pc=0xFC gives next 0x00, with no flag raised.
- RUN, stall=0: pc<=next; taken<=taken_now.
- RUN, stall=1: pc holds, taken<=0, branch ignored. stall has priority over br_valid; upstream re-presents br_valid.
- TRAP: pc holds, taken=0, br_valid/stall ignored; trap_ack=1 → pc<=TRAP_VEC, trap<=0, state RUN (trap_addr retains value).
- trap_ack in RUN ignored.

## Timing
- Next-address logic is combinational from inputs and pc. pc updates on the same edge the branch is presented: zero-cycle redirect latency.
- taken asserts the cycle pc shows the target and lasts exactly one cycle.
- Trap: the edge that samples the misaligned taken target sets trap=1 and trap_addr; pc keeps its old value. Trap exit takes one edge after trap_ack.
- Async reset mid-operation (any state) immediately forces the reset values. First fetch after deassertion is RESET_PC.

## Configuration
- PC_MISALIGN_TRAP_EN defined: a taken target with target[1:0]≠00 enters TRAP instead of updating pc. Sequential PC+4 never traps.
- Not defined: target[1:0] is forced to 00 and pc updates normally. trap and trap_addr are tied to 0, the TRAP state is unreachable, and trap_ack is ignored.

## Test plan
- Reset/sequential: rst_n low, then release. Expect pc=RESET_PC=0, then 4, 8, 12 on successive edges; taken=0.
- BEQ/BNE: pc=0x10, BEQ imm=4, zero_flag=1 → pc=0x18, taken=1 one cycle. Same with zero_flag=0 → pc=0x14. BNE with zero_flag=0 → 0x18.
- JALR and stall: rs1=0x101, imm=0x20, JALR → pc=0x120. Same stimulus with stall=1 → pc unchanged, taken=0.
- Wrap-around (ADDR_W=8): pc=0xFC sequential → 0x00. pc=0x04, BLT imm=-4, lt_flag=1 → pc=0xFC.
- Trap (macro on): pc=0x20, JAL imm=1 → trap=1, trap_addr=0x22, pc stays 0x20 while br_valid is ignored. trap_ack → pc=0x40, trap=0. Macro off: same stimulus → pc=0x20 (0x22 with low bits cleared), trap=0.
- Async reset mid-trap: rst_n low while trap=1 → trap=0, pc=RESET_PC immediately, with no clock edge required.
